// File: rtl/multi_cycle_cu.sv
// Multi-cycle CPU control unit: state sequencer plus combinational field decode.
// Optional feature macro: DMEM_WAIT_EN (adds MemReady; MEM stalls until ready).

`ifndef PC_NEXT_INS
`define PC_NEXT_INS 2'b00
`endif
`ifndef PC_REL_JMP
`define PC_REL_JMP 2'b01
`endif
`ifndef PC_ABS_JMP
`define PC_ABS_JMP 2'b10
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'b001
`endif
`ifndef ALU_AND
`define ALU_AND 3'b010
`endif
`ifndef ALU_OR
`define ALU_OR 3'b011
`endif
`ifndef ALU_SLL
`define ALU_SLL 3'b100
`endif
`ifndef ALU_SLT
`define ALU_SLT 3'b101
`endif
`ifndef REG_FROM_ALU
`define REG_FROM_ALU 1'b0
`endif
`ifndef REG_FROM_DATAMEMORY
`define REG_FROM_DATAMEMORY 1'b1
`endif
`ifndef SRCA_REG
`define SRCA_REG 1'b0
`endif
`ifndef SRCA_SHAMT
`define SRCA_SHAMT 1'b1
`endif
`ifndef SRCB_REG
`define SRCB_REG 1'b0
`endif
`ifndef SRCB_IMM
`define SRCB_IMM 1'b1
`endif
`ifndef REG_DST_RT
`define REG_DST_RT 1'b0
`endif
`ifndef REG_DST_RD
`define REG_DST_RD 1'b1
`endif
`ifndef EXT_ZERO
`define EXT_ZERO 1'b0
`endif
`ifndef EXT_SIGN
`define EXT_SIGN 1'b1
`endif

module multi_cycle_cu #(
  localparam int unsigned OP_W    = 6,
  localparam int unsigned ST_W    = 3,
  localparam int unsigned PCSRC_W = 2,
  localparam int unsigned ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    Opcode,
  input  logic [OP_W-1:0]    Funct,
  input  logic               Zero,
  input  logic               Sign,
`ifdef DMEM_WAIT_EN
  input  logic               MemReady,
`endif
  output logic [ST_W-1:0]    State,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               ExtSel,
  output logic [PCSRC_W-1:0] PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Halted
);

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLL = 6'b000000;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  typedef enum logic [ST_W-1:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   mem_ready;
  logic   branch_taken;

`ifdef DMEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  assign State  = ST_W'(state_q);
  assign Halted = (state_q == S_HALT);

  // Branch condition, meaningful only while the ALU flags are valid in EXE
  always_comb begin
    branch_taken = 1'b0;
    case (Opcode)
      OP_BEQ:  branch_taken = Zero;
      OP_BNE:  branch_taken = ~Zero;
      OP_BGTZ: branch_taken = ~Zero & ~Sign;
      default: branch_taken = 1'b0;
    endcase
  end

  // Datapath mux selects and ALU operation decoded straight from the instruction fields
  always_comb begin
    ALUSrcA  = `SRCA_REG;
    ALUSrcB  = `SRCB_REG;
    RegDst   = `REG_DST_RT;
    MemToReg = `REG_FROM_ALU;
    ExtSel   = `EXT_ZERO;
    ALUOp    = `ALU_ADD;
    case (Opcode)
      OP_RTYPE: begin
        RegDst = `REG_DST_RD;
        case (Funct)
          FN_ADD:  ALUOp = `ALU_ADD;
          FN_SUB:  ALUOp = `ALU_SUB;
          FN_AND:  ALUOp = `ALU_AND;
          FN_OR:   ALUOp = `ALU_OR;
          FN_SLL: begin
            ALUOp   = `ALU_SLL;
            ALUSrcA = `SRCA_SHAMT;
          end
          FN_SLT:  ALUOp = `ALU_SLT;
          default: ALUOp = `ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        ALUSrcB = `SRCB_IMM;
        ExtSel  = `EXT_SIGN;
        ALUOp   = `ALU_ADD;
      end
      OP_ORI: begin
        ALUSrcB = `SRCB_IMM;
        ExtSel  = `EXT_ZERO;
        ALUOp   = `ALU_OR;
      end
      OP_LW: begin
        ALUSrcB  = `SRCB_IMM;
        ExtSel   = `EXT_SIGN;
        MemToReg = `REG_FROM_DATAMEMORY;
        ALUOp    = `ALU_ADD;
      end
      OP_SW: begin
        ALUSrcB = `SRCB_IMM;
        ExtSel  = `EXT_SIGN;
        ALUOp   = `ALU_ADD;
      end
      OP_BEQ, OP_BNE, OP_BGTZ: begin
        ExtSel = `EXT_SIGN;
        ALUOp  = `ALU_SUB;
      end
      default: ;
    endcase
  end

  // State register; reset abandons any instruction in flight and leaves HALT
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and write-enable/strobe generation from the current state
  always_comb begin
    state_d  = state_q;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    PCSrc    = `PC_NEXT_INS;
    case (state_q)
      S_IF: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        PCSrc   = `PC_NEXT_INS;
        state_d = S_ID;
      end
      S_ID: begin
        case (Opcode)
          OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW,
          OP_BEQ, OP_BNE, OP_BGTZ: state_d = S_EXE;
          OP_J: begin
            PCWrite = 1'b1;
            PCSrc   = `PC_ABS_JMP;
            state_d = S_IF;
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_IF;
        endcase
      end
      S_EXE: begin
        case (Opcode)
          OP_RTYPE, OP_ADDI, OP_ORI: state_d = S_WB;
          OP_LW, OP_SW:              state_d = S_MEM;
          OP_BEQ, OP_BNE, OP_BGTZ: begin
            if (branch_taken) begin
              PCWrite = 1'b1;
              PCSrc   = `PC_REL_JMP;
            end
            state_d = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (Opcode == OP_LW) begin
          MemRead = 1'b0;
        end
        if (Opcode == OP_SW) begin
          MemWrite = 1'b0;
        end
        if (mem_ready) begin
          state_d = (Opcode == OP_LW) ? S_WB : S_IF;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    // Reset holds every enable and strobe inactive even though the state already reads IF
    if (!Reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b1;
      MemWrite = 1'b1;
      PCSrc    = `PC_NEXT_INS;
    end
  end

endmodule
